// File: rtl/rr_dispatcher_pkg.sv
// Shared defaults and types for the round-robin dispatcher.
package rr_dispatcher_pkg;

    localparam int DEFAULT_NUM_PORTS = 4;
    localparam int DEFAULT_DATA_W    = 8;
    localparam int PORT_IDX_W        = $clog2(DEFAULT_NUM_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/rr_dispatcher_prio_pick.sv
// LSB-first fixed-priority picker: one-hot grant of the lowest set request bit.
module prio_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_req[i] && !w_found) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: spreads an upstream stream over NUM_PORTS
// single-entry output slots, starting the search just after the last loaded port.
module rr_dispatcher
    import rr_dispatcher_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_i,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic                          in_ready_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    output logic [$clog2(NUM_PORTS)-1:0]  last_port_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]             r_valid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] r_data;
    logic [IDX_W-1:0]                 r_last;

    logic [NUM_PORTS-1:0] w_avail;
    logic [NUM_PORTS-1:0] w_mask;
    logic [NUM_PORTS-1:0] w_masked_req;
    logic [NUM_PORTS-1:0] w_masked_grant;
    logic [NUM_PORTS-1:0] w_unmasked_grant;
    logic [NUM_PORTS-1:0] w_grant;
    logic [IDX_W-1:0]     w_target;
    logic                 w_accept;

    // A full slot whose consumer is ready can be drained and refilled on one edge.
    assign w_avail      = ~r_valid | out_ready_i;
    assign in_ready_o   = (|w_avail) & ~reset;
    assign w_accept     = in_valid_i & in_ready_o;
    assign w_masked_req = w_avail & w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_mask[i] = (IDX_W'(i) > r_last);
        end
    end

    prio_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_masked (
        .i_req   (w_masked_req),
        .o_grant (w_masked_grant)
    );

    prio_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_unmasked (
        .i_req   (w_avail),
        .o_grant (w_unmasked_grant)
    );

    // Nothing free above the last port means the search wraps to port 0.
    assign w_grant = (|w_masked_req) ? w_masked_grant : w_unmasked_grant;

    always_comb begin
        w_target = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_target = w_target | IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
            r_last  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept && w_grant[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in_data_i;
                end else if (out_ready_i[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_last <= w_target;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign last_port_o = r_last;

endmodule
